// File: rtl/aes_loopback_pkg.sv
// Shared constants and helpers for the encrypt/buffer/decrypt loopback.
// The 64-bit block cipher is a 4-round ARX construction. Each round mixes in a
// rotated copy of the key, adds a round constant and rotates by 13. Every step
// can be undone, so the decrypt core runs the rounds in reverse.
package aes_loopback_pkg;

  localparam int BLOCK_W    = 64;
  localparam int KEY_W      = 64;
  localparam int INJECT_BIT = 0;   // ciphertext bit flipped by inject_err (lane 0)
  localparam int ROUNDS     = 4;

  // Width of one FIFO entry: {ciphertext, plaintext, key, bypass}
  function automatic int entry_w(input int lanes);
    return 2 * BLOCK_W * lanes + KEY_W + 1;
  endfunction

  function automatic logic [BLOCK_W-1:0] round_const(input int r);
    logic [BLOCK_W-1:0] c;
    case (r)
      0:       c = 64'h9E3779B97F4A7C15;
      1:       c = 64'hBF58476D1CE4E5B9;
      2:       c = 64'h94D049BB133111EB;
      3:       c = 64'hD6E8FEB86659FD93;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Each round uses the key rotated left by a further byte
  function automatic logic [BLOCK_W-1:0] round_key(input logic [KEY_W-1:0] key, input int r);
    logic [KEY_W-1:0] k;
    k = (r == 0) ? key : ((key << (8 * r)) | (key >> (KEY_W - 8 * r)));
    return k ^ round_const(r);
  endfunction

  function automatic logic [BLOCK_W-1:0] rotl13(input logic [BLOCK_W-1:0] x);
    return {x[BLOCK_W-14:0], x[BLOCK_W-1:BLOCK_W-13]};
  endfunction

  function automatic logic [BLOCK_W-1:0] rotr13(input logic [BLOCK_W-1:0] x);
    return {x[12:0], x[BLOCK_W-1:13]};
  endfunction

endpackage

// File: rtl/aes_dec64.sv
// Combinational 64-bit block decrypt core (single lane), inverse of aes_enc64.
module aes_dec64
  import aes_loopback_pkg::*;
(
  input  logic [BLOCK_W-1:0] cipher,
  input  logic [KEY_W-1:0]   key,
  output logic [BLOCK_W-1:0] block
);

  logic [BLOCK_W-1:0] state;

  // Undo the rounds in reverse order: rotate back, subtract constant, xor key
  always_comb begin
    state = cipher;
    for (int r = ROUNDS - 1; r >= 0; r--) begin
      state = (rotr13(state) - round_const(r)) ^ round_key(key, r);
    end
    block = state;
  end

endmodule

// File: rtl/aes_enc64.sv
// Combinational 64-bit block encrypt core (single lane).
module aes_enc64
  import aes_loopback_pkg::*;
(
  input  logic [BLOCK_W-1:0] block,
  input  logic [KEY_W-1:0]   key,
  output logic [BLOCK_W-1:0] cipher
);

  logic [BLOCK_W-1:0] state;

  // Unrolled round chain: xor round key, add constant, rotate
  always_comb begin
    // NOTE: state gets a value on entry, so no path leaves it unassigned
    // and no latch is inferred.
    state = block;
    for (int r = 0; r < ROUNDS; r++) begin
      state = rotl13((state ^ round_key(key, r)) + round_const(r));
    end
    cipher = state;
  end

endmodule

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count.
// A push while full and a pop while empty are ignored. DEPTH must be a power
// of two, so the pointers wrap by plain overflow.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = count;
  assign rdata   = mem[rd_ptr];

  // Storage write
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset. Pointers and count define which entries
    // are valid, and leaving the array unreset lets it map onto RAM.
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register updates from the
    // values sampled before the edge.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_loopback_pipe.sv
// Multi-lane encrypt -> FIFO -> decrypt loopback with self-check counters.
// Each accepted beat stores {ciphertext, plaintext, key, bypass}. The head
// entry is decrypted with its own stored key and bypass and compared against
// its stored plaintext.
module aes_loopback_pipe
  import aes_loopback_pkg::*;
#(
  parameter int LANES = 1,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BLOCK_W*LANES-1:0]   in_data,
  input  logic [KEY_W-1:0]           key,
  input  logic                       bypass,
  input  logic                       inject_err,
  output logic                       enc_valid,
  output logic [BLOCK_W*LANES-1:0]   enc_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BLOCK_W*LANES-1:0]   out_data,
  output logic                       out_match,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       full,
  output logic                       empty,
  input  logic                       clear_counts,
  output logic [CNT_W-1:0]           pass_count,
  output logic [CNT_W-1:0]           fail_count
);

  localparam int DW = BLOCK_W * LANES;
  localparam int EW = entry_w(LANES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic          push;
  logic          pop;
  logic [DW-1:0] enc_word;
  logic [DW-1:0] cipher_word;
  logic [DW-1:0] inject_mask;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head_entry;
  logic [DW-1:0] head_cipher;
  logic [DW-1:0] head_plain;
  logic [KEY_W-1:0] head_key;
  logic          head_bypass;
  logic [DW-1:0] dec_word;

  // Handshake: no pass-through when full, FWFT output whenever not empty
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Per-lane cipher cores with a bypass mux around each
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [BLOCK_W-1:0] lane_enc;
    logic [BLOCK_W-1:0] lane_dec;

    aes_enc64 u_enc (
      .block  (in_data[i*BLOCK_W +: BLOCK_W]),
      .key    (key),
      .cipher (lane_enc)
    );

    aes_dec64 u_dec (
      .cipher (head_cipher[i*BLOCK_W +: BLOCK_W]),
      .key    (head_key),
      .block  (lane_dec)
    );

    assign enc_word[i*BLOCK_W +: BLOCK_W] = bypass      ? in_data[i*BLOCK_W +: BLOCK_W]     : lane_enc;
    assign dec_word[i*BLOCK_W +: BLOCK_W] = head_bypass ? head_cipher[i*BLOCK_W +: BLOCK_W] : lane_dec;
  end

  // Test hook: corrupt one lane-0 ciphertext bit before it is stored
  assign inject_mask = DW'(inject_err) << INJECT_BIT;
  assign cipher_word = enc_word ^ inject_mask;

  assign wr_entry = {cipher_word, in_data, key, bypass};
  assign {head_cipher, head_plain, head_key, head_bypass} = head_entry;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head_entry),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  assign out_data  = dec_word;
  assign out_match = (dec_word == head_plain);

  // Saturating pass/fail counters; clear takes priority over a same-cycle pop
  always_ff @(posedge clk) begin
    if (rst || clear_counts) begin
      pass_count <= '0;
      fail_count <= '0;
    end else if (pop) begin
      if (out_match) begin
        if (pass_count != CNT_MAX) pass_count <= pass_count + 1'b1;
      end else begin
        if (fail_count != CNT_MAX) fail_count <= fail_count + 1'b1;
      end
    end
  end

  // Ciphertext tap: one-cycle valid per push, data holds between pushes
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_valid <= 1'b0;
      enc_data  <= '0;
    end else begin
      enc_valid <= push;
      if (push) enc_data <= cipher_word;
    end
  end

endmodule

// File: tb/tb_aes_loopback_pipe.sv
// Self-checking bench for aes_loopback_pipe (LANES=2, DEPTH=8, CNT_W=8).
// A negedge monitor keeps a reference queue of expected pops, reference
// counters and the expected ciphertext tap, and compares them with the DUT.
module tb_aes_loopback_pipe;

  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int DW    = 64 * LANES;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [63:0]      key;
  logic             bypass;
  logic             inject_err;
  logic             enc_valid;
  logic [DW-1:0]    enc_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             out_match;
  logic [LW-1:0]    fifo_level;
  logic             full;
  logic             empty;
  logic             clear_counts;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;

  always #5 clk = ~clk;

  aes_loopback_pipe #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .key          (key),
    .bypass       (bypass),
    .inject_err   (inject_err),
    .enc_valid    (enc_valid),
    .enc_data     (enc_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_match    (out_match),
    .fifo_level   (fifo_level),
    .full         (full),
    .empty        (empty),
    .clear_counts (clear_counts),
    .pass_count   (pass_count),
    .fail_count   (fail_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          match;
  } exp_t;

  exp_t             sb_q[$];
  bit               mon_on   = 1'b0;
  logic [CNT_W-1:0] m_pass   = '0;
  logic [CNT_W-1:0] m_fail   = '0;
  int               pop_seen = 0;
  bit               prev_push  = 1'b0;
  bit               prev_known = 1'b0;
  logic [DW-1:0]    prev_enc   = '0;

  // Reference model, evaluated mid-cycle on the values the next edge will see
  always @(negedge clk) begin : monitor
    exp_t          e;
    int            lvl;
    logic [DW-1:0] stored;
    if (mon_on) begin
      lvl = sb_q.size();
      check("enc_valid", enc_valid, prev_push);
      if (prev_push && prev_known) check("enc_data", enc_data, prev_enc);
      check("pass_count", pass_count, m_pass);
      check("fail_count", fail_count, m_fail);
      check("fifo_level", fifo_level, lvl);
      check("empty", empty, lvl == 0);
      check("full", full, lvl == DEPTH);
      check("in_ready", in_ready, lvl < DEPTH);
      check("out_valid", out_valid, lvl > 0);
      if (rst) begin
        sb_q.delete();
        m_pass    = '0;
        m_fail    = '0;
        prev_push = 1'b0;
      end else begin
        if (lvl > 0 && out_ready) begin
          e = sb_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_match", out_match, e.match);
          pop_seen++;
          if (e.match) begin
            if (m_pass != '1) m_pass = m_pass + 1'b1;
          end else begin
            if (m_fail != '1) m_fail = m_fail + 1'b1;
          end
        end
        if (clear_counts) begin
          m_pass = '0;
          m_fail = '0;
        end
        prev_push = in_valid && (lvl < DEPTH);
        if (prev_push) begin
          // Inject is only used with bypass=1, where the stored ciphertext is
          // the plaintext with bit 0 flipped and decrypt is identity.
          stored     = in_data ^ DW'(inject_err);
          e.data     = stored;
          e.match    = !inject_err;
          sb_q.push_back(e);
          prev_known = bypass;
          prev_enc   = stored;
        end
      end
    end
  end

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    key          = 64'h0F1E2D3C4B5A6978;
    bypass       = 1'b0;
    inject_err   = 1'b0;
    out_ready    = 1'b0;
    clear_counts = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", fifo_level, 0);
    check("rst_enc_valid", enc_valid, 0);
    check("rst_enc_data", enc_data, 0);
    check("rst_pass", pass_count, 0);
    check("rst_fail", fail_count, 0);
    rst    = 1'b0;
    mon_on = 1'b1;

    // Bypass beat with immediate pop
    bypass    = 1'b1;
    out_ready = 1'b1;
    in_data   = 128'h0123456789ABCDEF_FEDCBA9876543210;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 128'h0123456789ABCDEF_FEDCBA9876543210);
    check("t1_out_match", out_match, 1);
    tick();
    check("t1_pass", pass_count, 1);

    // Injected error under bypass
    in_data    = '0;
    inject_err = 1'b1;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    inject_err = 1'b0;
    check("t2_enc_data", enc_data, 128'h1);
    check("t2_out_data", out_data, 128'h1);
    check("t2_out_match", out_match, 0);
    tick();
    check("t2_fail", fail_count, 1);
    check("t2_pass", pass_count, 1);

    // Fill to full with downstream stalled, then drain in order
    bypass    = 1'b0;
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      in_data  = {64'(i), 64'(i)};
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("t3_full", full, 1);
    check("t3_in_ready", in_ready, 0);
    check("t3_level", fifo_level, 8);
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("t3_order", out_data, {64'(k), 64'(k)});
      tick();
    end
    check("t3_level_end", fifo_level, 0);
    check("t3_empty", empty, 1);

    // Random traffic with a new key every beat
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    begin
      int base;
      base = pop_seen;
      for (int c = 0; c < 150; c++) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        key       = {$urandom, $urandom};
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (DEPTH + 1) tick();
      check("t4_pass_eq_pops", pass_count, pop_seen - base);
      check("t4_fail", fail_count, 0);
    end

    // Saturation, then clear against a same-cycle pop
    bypass   = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 270; i++) begin
      in_data = {64'(i), ~64'(i)};
      tick();
    end
    check("t5_sat", pass_count, 8'hFF);
    tick();
    check("t5_sat_hold", pass_count, 8'hFF);
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    in_valid     = 1'b0;
    check("t5_clear_pass", pass_count, 0);
    check("t5_clear_fail", fail_count, 0);
    repeat (2) tick();

    // Reset mid-stream with a beat offered in the reset cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = {64'hA5A5, 64'(i)};
      tick();
    end
    check("t6_level3", fifo_level, 3);
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("t6_level", fifo_level, 0);
    check("t6_empty", empty, 1);
    check("t6_out_valid", out_valid, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_pass", pass_count, 0);
    check("t6_fail", fail_count, 0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_loopback_pipe.md
# aes_loopback_pipe

Streaming, multi-lane encrypt→buffer→decrypt loopback with built-in self-check. It accepts plaintext beats on a valid/ready handshake, encrypts each 64-bit lane with the team's combinational 64-bit encrypt core, and buffers ciphertext, plaintext and key per beat in a parametrised FIFO. It then decrypts at the FIFO head and compares each result against the stored plaintext, keeping saturating pass/fail counters. It is the parametrised successor to the single-lane AES top and replaces the fixed FIFO and combinational scoreboard with a handshaked, counted datapath.

## Interface
- LANES, 1: number of independent 64-bit lanes per beat (≥1)
- DEPTH, 8: FIFO entries, power of two, ≥2
- CNT_W, 16: width of pass/fail counters
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept a beat
- in_data  in  64*LANES  plaintext; lane i = bits [64i+63:64i]
- key  in  64  key; sampled with each accepted beat, shared by all lanes
- bypass  in  1  1 = encrypt and decrypt replaced by identity; sampled per beat
- inject_err  in  1  1 = flip bit 0 of lane 0 ciphertext before storing (test hook)
- enc_valid  out  1  ciphertext tap valid (one-cycle pulse per accepted beat)
- enc_data  out  64*LANES  ciphertext of the last accepted beat
- out_valid  out  1  decrypted beat available
- out_ready  in  1  downstream accepts
- out_data  out  64*LANES  decrypted data at FIFO head
- out_match  out  1  all lanes of out_data equal the stored plaintext
- fifo_level  out  $clog2(DEPTH+1)  occupied entries
- full, empty  out  1  FIFO status
- clear_counts  in  1  synchronous clear of both counters
- pass_count, fail_count  out  CNT_W  saturating counts of matched/mismatched pops

## Operation
- Push: in_valid && in_ready. Entry = {ciphertext (after inject_err), plaintext, key, bypass}.
- in_ready = !full. No same-cycle pass-through when full, even if a pop occurs.
- Pop: out_valid && out_ready. out_valid = !empty.
- The FIFO is first-word fall-through. out_data and out_match derive combinationally from the head entry, using the stored key and stored bypass, not the live inputs.
- Push and pop in the same cycle: level unchanged. Pointers wrap modulo DEPTH.
- On each pop: if out_match = 1, pass_count += 1; otherwise fail_count += 1. Both counters saturate at all-ones.
- If clear_counts is asserted, both counters read 0 after the edge. Clear wins over a same-cycle increment, and that pop is not counted.
- enc_valid/enc_data are registered. They show the accepted beat's stored ciphertext on the cycle after the push; enc_data holds between pushes.
- Lanes share the handshake and the key. A mismatch in any lane makes out_match = 0.

## Timing
- Reset values: in_ready=1, out_valid=0, empty=1, full=0, fifo_level=0, enc_valid=0, enc_data=0, pass_count=0, fail_count=0. FIFO memory is not reset.
- out_data and out_match are don't-care while out_valid=0.
- Latency: a beat pushed at edge N is at the output from cycle N+1 if the FIFO was empty. The minimum push-to-pop latency is 1 cycle.
- Throughput: 1 beat/cycle sustained while neither full nor stalled.
- rst asserted mid-stream discards all entries. Outputs take reset values after the edge, and a handshake in the reset cycle is ignored.
- Holding out_ready=0 lets the FIFO fill to DEPTH; in_ready drops in the cycle the level reaches DEPTH.

## Structure
- Package aes_loopback_pkg holds:
  - BLOCK_W=64 and KEY_W=64
  - the packed entry typedef parameterised via LANES, or a width function
  - the bit index for inject_err
- Sub-module sync_fifo holds storage, pointers, level, full/empty and FWFT read. It has a generic WIDTH/DEPTH and its own synchronous active-high rst.
- Per-lane generate loop instantiates the existing combinational encrypt and decrypt cores; a bypass mux sits around each.
- Counters and enc tap register live in the top.

## Test plan
- LANES=2, bypass=1, push in_data=128'h0123456789ABCDEF_FEDCBA9876543210 with out_ready=1 → out_valid next cycle, out_data equal to the input, out_match=1, pass_count=1.
- bypass=1, inject_err=1, in_data=64'h0 → enc_data=64'h1 next cycle; on pop out_data=64'h1, out_match=0, fail_count=1, pass_count unchanged.
- DEPTH=8, out_ready=0, 9 consecutive valid beats 1..9 → 8 accepted, full=1, in_ready=0, fifo_level=8. Then out_ready=1 → beats 1..8 emerge in order and level returns to 0.
- bypass=0, key changes every beat, random data, random out_ready → every pop has out_match=1, and pass_count equals the number of pops.
- Drive pass_count to all-ones, then pop again → it stays all-ones. clear_counts in the same cycle as a pop → both counters 0.
- Fill with 3 entries, assert rst for one cycle with in_valid=1 → fifo_level=0, empty=1, out_valid=0, and no counter change.
